// File: rtl/branch_gshare_pkg.sv
// Shared constants and helpers for the gshare branch predictor:
// branch opcodes, counter reset value and saturating arithmetic.
package branch_gshare_pkg;

  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [5:0]  OP_BNE    = 6'b000101;
  localparam int unsigned CTR_MAX_W = 4;

  function automatic logic is_branch(input logic [31:0] insn);
    return (insn[31:26] == OP_BEQ) || (insn[31:26] == OP_BNE);
  endfunction

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic logic [CTR_MAX_W-1:0] ctr_reset_val(input int unsigned w);
    int unsigned v;
    v = (32'd1 << (w - 32'd1)) - 32'd1;
    return CTR_MAX_W'(v);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] v,
                                                   input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (v == CTR_MAX_W'(mx)) ? v : v + CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] v);
    return (v == '0) ? v : v - CTR_MAX_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_gshare_sat_counter_array.sv
// Pattern history table: array of saturating counters with one
// combinational read port and one increment/decrement write port.
module sat_counter_array
  import branch_gshare_pkg::*;
#(
  parameter int unsigned DEPTH_W = 8,
  parameter int unsigned WIDTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DEPTH_W-1:0] rd_idx,
  output logic [WIDTH-1:0]   rd_ctr,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] wr_idx,
  input  logic               wr_up
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_W;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [CTR_MAX_W-1:0] cur_wide;
  logic [WIDTH-1:0]     nxt;

  // Read sees the pre-update value when read and write hit the same entry.
  assign rd_ctr   = mem[rd_idx];
  assign cur_wide = CTR_MAX_W'(mem[wr_idx]);

  always_comb begin
    nxt = mem[wr_idx];
    if (wr_up) nxt = WIDTH'(sat_inc(cur_wide, WIDTH));
    else       nxt = WIDTH'(sat_dec(cur_wide));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(ctr_reset_val(WIDTH));
    end else if (wr_en) begin
      mem[wr_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_gshare.sv
// Gshare direction predictor with saved IF/ID stage and statistics.
// Optional BTB enabled by defining BRANCH_BTB_EN.
module branch_gshare
  import branch_gshare_pkg::*;
#(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned HIST_W    = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Iadd,
  input  logic [31:0] Idata,
  input  logic [31:0] Badd,
  input  logic [31:0] Bdata,
  input  logic        result,
  input  logic        if_id_write,
  input  logic        flush,
  output logic        predict,
  output logic [31:0] predict_target,
  output logic        btb_hit,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  logic [HIST_W-1:0] ghr;
  logic [HIST_W-1:0] ghr_next;
  logic [IDX_W-1:0]  lookup_idx;
  logic [IDX_W-1:0]  s_idx;
  logic [CTR_W-1:0]  rd_ctr;
  logic              s_pred;
  logic              s_br;
  logic              fetch_br;
  logic              dir_pred;
  logic              resolve;

  assign fetch_br   = is_branch(Idata);
  assign lookup_idx = Iadd[IDX_W+1:2] ^ IDX_W'(ghr);
  assign dir_pred   = fetch_br & rd_ctr[CTR_W-1];
  // Flush wins over a coincident resolve.
  assign resolve    = s_br & is_branch(Bdata) & if_id_write & ~flush;

  generate
    if (HIST_W == 1) begin : g_hist1
      assign ghr_next = result;
    end else begin : g_histn
      assign ghr_next = {ghr[HIST_W-2:0], result};
    end
  endgenerate

  sat_counter_array #(
    .DEPTH_W (IDX_W),
    .WIDTH   (CTR_W)
  ) u_pht (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (lookup_idx),
    .rd_ctr (rd_ctr),
    .wr_en  (resolve),
    .wr_idx (s_idx),
    .wr_up  (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr        <= '0;
      s_idx      <= '0;
      s_pred     <= 1'b0;
      s_br       <= 1'b0;
      br_count   <= '0;
      mp_count   <= '0;
      mispredict <= 1'b0;
    end else begin
      mispredict <= resolve & (s_pred != result);
      if (resolve) begin
        ghr      <= ghr_next;
        br_count <= sat_inc32(br_count);
        if (s_pred != result) mp_count <= sat_inc32(mp_count);
      end
      if (flush) begin
        s_br <= 1'b0;
      end else if (if_id_write) begin
        s_idx  <= lookup_idx;
        s_pred <= predict;
        s_br   <= fetch_br;
      end
    end
  end

`ifdef BRANCH_BTB_EN
  localparam int unsigned BTB_DEPTH = 32'd1 << BTB_IDX_W;
  localparam int unsigned TAG_W     = 30 - BTB_IDX_W;

  logic                 btb_valid [BTB_DEPTH];
  logic [TAG_W-1:0]     btb_tag   [BTB_DEPTH];
  logic [31:0]          btb_tgt   [BTB_DEPTH];
  logic [BTB_IDX_W-1:0] rd_bi;
  logic [BTB_IDX_W-1:0] wr_bi;
  logic [31:0]          branch_target;
  logic                 btb_wr;
  logic                 unused_sink;

  assign rd_bi          = Iadd[BTB_IDX_W+1:2];
  assign wr_bi          = Badd[BTB_IDX_W+1:2];
  assign branch_target  = Badd + 32'd4 + {{14{Bdata[15]}}, Bdata[15:0], 2'b00};
  assign btb_wr         = resolve & result;
  assign btb_hit        = btb_valid[rd_bi] && (btb_tag[rd_bi] == Iadd[31:BTB_IDX_W+2]);
  assign predict_target = btb_hit ? btb_tgt[rd_bi] : Iadd + 32'd4;
  assign predict        = dir_pred & btb_hit;
  assign unused_sink    = ^{Idata[25:0], Bdata[25:16], rd_ctr[CTR_W-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) btb_valid[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_valid[wr_bi] <= 1'b1;
    end
  end

  // Tag and target need no reset: they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr && !rst) begin
      btb_tag[wr_bi] <= Badd[31:BTB_IDX_W+2];
      btb_tgt[wr_bi] <= branch_target;
    end
  end
`else
  logic unused_sink;

  assign btb_hit        = 1'b0;
  assign predict_target = Iadd + 32'd4;
  assign predict        = dir_pred;
  assign unused_sink    = ^{Badd, Idata[25:0], Bdata[25:0], rd_ctr[CTR_W-2:0], 32'(BTB_IDX_W)};
`endif

endmodule

// File: tb/tb_branch_gshare.sv
// Self-checking bench for branch_gshare: directed scenarios plus randomized
// traffic against a behavioural predictor model. Honours BRANCH_BTB_EN.
module tb_branch_gshare;

  localparam int unsigned IDX_W     = 8;
  localparam int unsigned HIST_W    = 8;
  localparam int unsigned CTR_W     = 2;
  localparam int unsigned BTB_IDX_W = 4;
  localparam int unsigned PHT_N     = 1 << IDX_W;
  localparam int unsigned BTB_N     = 1 << BTB_IDX_W;
  localparam int unsigned CTR_MAX   = (1 << CTR_W) - 1;
  localparam int unsigned CTR_RST   = (1 << (CTR_W - 1)) - 1;
  localparam int unsigned CTR_HALF  = 1 << (CTR_W - 1);
  localparam logic [31:0] BEQ       = 32'h1000_0000;
  localparam logic [31:0] BNE       = 32'h1400_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Iadd, Idata, Badd, Bdata;
  logic        result, if_id_write, flush;
  logic        predict, btb_hit, mispredict;
  logic [31:0] predict_target, br_count, mp_count;

  always #5 clk = ~clk;

  branch_gshare #(
    .IDX_W     (IDX_W),
    .HIST_W    (HIST_W),
    .CTR_W     (CTR_W),
    .BTB_IDX_W (BTB_IDX_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Iadd           (Iadd),
    .Idata          (Idata),
    .Badd           (Badd),
    .Bdata          (Bdata),
    .result         (result),
    .if_id_write    (if_id_write),
    .flush          (flush),
    .predict        (predict),
    .predict_target (predict_target),
    .btb_hit        (btb_hit),
    .mispredict     (mispredict),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int unsigned pht [PHT_N];
  int unsigned ghr, s_idx, m_br, m_mp;
  bit          s_pred, s_br, m_mis;
  bit          bv [BTB_N];
  int unsigned btag [BTB_N];
  logic [31:0] btgt [BTB_N];
  logic        obs_pred, obs_hit;
  logic [31:0] obs_tgt;

  function automatic bit is_br(input logic [31:0] w);
    int unsigned op;
    op = w >> 26;
    return op == 4 || op == 5;
  endfunction

  function automatic int unsigned model_idx(input logic [31:0] a);
    return ((a >> 2) ^ ghr) % PHT_N;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
`ifdef BRANCH_BTB_EN
    int unsigned b;
    b = (a >> 2) % BTB_N;
    return bv[b] && btag[b] == (a >> (BTB_IDX_W + 2));
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] a);
    if (model_hit(a)) return btgt[(a >> 2) % BTB_N];
    return a + 32'd4;
  endfunction

  function automatic bit model_pred(input logic [31:0] a, input logic [31:0] d);
    bit p;
    p = is_br(d) && pht[model_idx(a)] >= CTR_HALF;
`ifdef BRANCH_BTB_EN
    p = p && model_hit(a);
`endif
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PHT_N; i++) pht[i] = CTR_RST;
    for (int i = 0; i < BTB_N; i++) bv[i] = 0;
    ghr = 0; s_idx = 0; s_pred = 0; s_br = 0; m_br = 0; m_mp = 0; m_mis = 0;
  endtask

  // One clock cycle: inputs are already driven (edge + 1).
  task automatic step();
    int unsigned lidx;
    bit          lpred, lbr, res_now;
    logic [31:0] nb_add, nb_data;
    int          off;
    #3;
    obs_pred = predict; obs_hit = btb_hit; obs_tgt = predict_target;
    check_eq("predict", predict, model_pred(Iadd, Idata));
    check_eq("btb_hit", btb_hit, model_hit(Iadd));
    check_eq("predict_target", predict_target, model_target(Iadd));
    lidx    = model_idx(Iadd);
    lpred   = model_pred(Iadd, Idata);
    lbr     = is_br(Idata);
    res_now = s_br && is_br(Bdata) && if_id_write && !flush;
    m_mis   = 0;
    if (res_now) begin
      if (result) pht[s_idx] = (pht[s_idx] == CTR_MAX) ? CTR_MAX : pht[s_idx] + 1;
      else        pht[s_idx] = (pht[s_idx] == 0) ? 0 : pht[s_idx] - 1;
      ghr = ((ghr << 1) | result) % (1 << HIST_W);
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (s_pred != result) begin
        m_mis = 1;
        if (m_mp != 32'hFFFF_FFFF) m_mp++;
      end
      if (result) begin
        off = $signed(Bdata[15:0]);
        bv[(Badd >> 2) % BTB_N]   = 1;
        btag[(Badd >> 2) % BTB_N] = Badd >> (BTB_IDX_W + 2);
        btgt[(Badd >> 2) % BTB_N] = Badd + 32'd4 + 32'(off * 4);
      end
    end
    nb_add = Badd; nb_data = Bdata;
    if (flush) begin
      s_br = 0; nb_add = '0; nb_data = '0;
    end else if (if_id_write) begin
      s_idx = lidx; s_pred = lpred; s_br = lbr; nb_add = Iadd; nb_data = Idata;
    end
    @(posedge clk); #1;
    Badd = nb_add; Bdata = nb_data;
    check_eq("mispredict", mispredict, m_mis);
    check_eq("br_count", br_count, m_br);
    check_eq("mp_count", mp_count, m_mp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic res, input logic wr, input logic fl);
    Iadd = a; Idata = d; result = res; if_id_write = wr; flush = fl;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; if_id_write = 1'b0; flush = 1'b0; result = 1'b0;
    Iadd = 32'h100; Idata = BEQ; Badd = '0; Bdata = '0;
    model_reset();
    #3;
    check_eq("rst_predict", predict, 1'b0);
    @(posedge clk); #1;
    check_eq("rst_br_count", br_count, 32'd0);
    check_eq("rst_mp_count", mp_count, 32'd0);
    check_eq("rst_mispredict", mispredict, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_predict", predict, 1'b0);
  endtask

  logic        tp [3];
  int unsigned saved, late;
  logic [31:0] a;

  initial begin
    rst = 1'b1; Iadd = '0; Idata = '0; Badd = '0; Bdata = '0;
    result = 1'b0; if_id_write = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Training: same PHT entry each lookup, one bubble between branches.
    for (int k = 0; k < 3; k++) begin
      drive((32'h40 ^ ghr) << 2, BEQ, 1'b1, 1'b1, 1'b0);
      tp[k] = obs_pred;
      drive(32'h300, 32'h0, 1'b1, 1'b1, 1'b0);
    end
`ifndef BRANCH_BTB_EN
    check_eq("train_pred0", tp[0], 1'b0);
    check_eq("train_pred1", tp[1], 1'b1);
    check_eq("train_pred2", tp[2], 1'b1);
    check_eq("train_mp", mp_count, 32'd1);
    check_eq("train_br", br_count, 32'd3);
`endif

    // Stall: a pending resolve must not be applied while IF/ID holds.
    drive(32'h1C0, BNE, 1'b0, 1'b1, 1'b0);
    saved = m_br;
    for (int k = 0; k < 5; k++) drive(32'h40 + 32'(k * 4), BEQ, 1'b1, 1'b0, 1'b0);
    check_eq("stall_br", br_count, saved);
    drive(32'h300, 32'h0, 1'b1, 1'b1, 1'b0);
    check_eq("stall_release_br", br_count, saved + 1);

    // Flush coincident with a would-be mispredict.
    drive(32'h2C0, BEQ, 1'b0, 1'b1, 1'b0);
    saved = m_mp;
    drive(32'h300, 32'h0, !obs_pred, 1'b1, 1'b1);
    check_eq("flush_mispredict", mispredict, 1'b0);
    check_eq("flush_mp", mp_count, saved);

    // History: alternating outcomes on one branch.
    do_reset();
    late = 0;
    for (int c = 0; c <= 32; c++) begin
      drive(32'h180, (c < 32) ? BEQ : 32'h0, (c % 2) == 1, 1'b1, 1'b0);
      if (c >= 17 && mispredict) late++;
    end
    check_eq("hist_late_mp", late, 0);
    check_eq("hist_br", br_count, 32'd32);

    // BTB fill from a taken BEQ at 0x200, offset 0x10.
    do_reset();
    drive(32'h200, BEQ | 32'h10, 1'b0, 1'b1, 1'b0);
    drive(32'h300, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(32'h200, BEQ, 1'b0, 1'b1, 1'b0);
`ifdef BRANCH_BTB_EN
    check_eq("btb_fill_hit", obs_hit, 1'b1);
    check_eq("btb_fill_target", obs_tgt, 32'h244);
`else
    check_eq("nobtb_hit", obs_hit, 1'b0);
    check_eq("nobtb_target", obs_tgt, 32'h204);
`endif

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2);
        case ($urandom_range(0, 3))
          0:       Idata = BEQ | 32'($urandom_range(0, 65535));
          1:       Idata = BNE | 32'($urandom_range(0, 65535));
          default: Idata = $urandom;
        endcase
        drive(a, Idata, 1'($urandom_range(0, 1)),
              $urandom_range(0, 6) != 0, $urandom_range(0, 9) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
